// File: rtl/laser_pkg.sv
// Shared definitions for the sprite drawers: FSM state encoding and default laser palette.
package laser_pkg;

    localparam int LASER_COLOUR_W = 3;

    typedef logic [LASER_COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam colour_t TIP_DEF  = 3'b100;
    localparam colour_t BODY_DEF = 3'b101;
    localparam colour_t BG_DEF   = 3'b000;

endpackage

// File: rtl/laser_drawer_if.sv
// Request/plot bundle between the game-control FSM (master) and the laser drawer (slave).
interface laser_drawer_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                erase;
    logic                vertical;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic                busy;
    logic                done;
    logic                plot;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour;

    modport master (
        output start, erase, vertical, x_in, y_in,
        input  busy, done, plot, x_out, y_out, colour
    );

    modport slave (
        input  start, erase, vertical, x_in, y_in,
        output busy, done, plot, x_out, y_out, colour
    );
endinterface

// File: rtl/laser_drawer_step_counter.sv
// Pixel index counter for one bolt: holds the index of the next pixel to emit and
// wraps to zero after the last one, so "first" doubles as an end-of-bolt marker.
module laser_step_counter #(
    parameter int LEN = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_enable,
    output logic [$clog2(LEN+1)-1:0] o_step,
    output logic                     o_first,
    output logic                     o_last
);
    localparam int CW = $clog2(LEN+1);

    logic [CW-1:0] r_step;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_step <= '0;
        end else if (i_enable) begin
            r_step <= o_last ? '0 : r_step + CW'(1);
        end
    end

    assign o_step  = r_step;
    assign o_first = (r_step == '0);
    assign o_last  = (r_step == CW'(LEN - 1));

endmodule

// File: rtl/laser_drawer.sv
// Laser bolt drawer: latches an origin on start and emits LEN framebuffer writes,
// one per cycle, horizontally or vertically, followed by a one-cycle done pulse.
module laser_drawer
    import laser_pkg::*;
#(
    parameter int                  X_W         = 8,
    parameter int                  Y_W         = 7,
    parameter int                  LEN         = 5,
    parameter int                  COLOUR_W    = LASER_COLOUR_W,
    parameter logic [COLOUR_W-1:0] TIP_COLOUR  = TIP_DEF,
    parameter logic [COLOUR_W-1:0] BODY_COLOUR = BODY_DEF,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = BG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    laser_drawer_if.slave bus
);
    localparam int CW = $clog2(LEN+1);

    state_t              r_state;
    state_t              w_nextState;

    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic                r_erase;
    logic                r_vertical;

    logic                r_busy;
    logic                r_done;
    logic                r_plot;
    logic [X_W-1:0]      r_xOut;
    logic [Y_W-1:0]      r_yOut;
    logic [COLOUR_W-1:0] r_colour;

    logic                w_accept;
    logic                w_emit;
    logic                w_clear;
    logic                w_nextBusy;
    logic                w_nextDone;

    logic [CW-1:0]       w_step;
    logic                w_first;
    logic                w_last;

    logic [X_W-1:0]      w_srcX;
    logic [Y_W-1:0]      w_srcY;
    logic                w_srcErase;
    logic                w_srcVertical;
    logic [X_W-1:0]      w_nextX;
    logic [Y_W-1:0]      w_nextY;
    logic [COLOUR_W-1:0] w_nextColour;

    laser_step_counter #(
        .LEN (LEN)
    ) u_stepCounter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_enable (w_emit),
        .o_step   (w_step),
        .o_first  (w_first),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // In DRAW the counter has already wrapped back to zero once the last pixel is out.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        w_clear     = 1'b0;
        w_nextBusy  = 1'b0;
        w_nextDone  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_emit      = 1'b1;
                    w_nextBusy  = 1'b1;
                    w_nextState = ST_DRAW;
                end
            end
            ST_DRAW: begin
                w_nextBusy = 1'b1;
                if (w_first) begin
                    w_nextDone  = 1'b1;
                    w_nextState = ST_DONE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            ST_DONE: begin
                w_clear     = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // The first pixel is emitted on the accepting edge, before the latches hold the origin.
    always_comb begin
        w_srcX        = w_accept ? bus.x_in     : r_x0;
        w_srcY        = w_accept ? bus.y_in     : r_y0;
        w_srcErase    = w_accept ? bus.erase    : r_erase;
        w_srcVertical = w_accept ? bus.vertical : r_vertical;
        w_nextX       = w_srcVertical ? w_srcX : w_srcX + X_W'(w_step);
        w_nextY       = w_srcVertical ? w_srcY + Y_W'(w_step) : w_srcY;
        if (w_srcErase) begin
            w_nextColour = BG_COLOUR;
        end else if (w_first || w_last) begin
            w_nextColour = TIP_COLOUR;
        end else begin
            w_nextColour = BODY_COLOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_erase    <= 1'b0;
            r_vertical <= 1'b0;
        end else if (w_accept) begin
            r_x0       <= bus.x_in;
            r_y0       <= bus.y_in;
            r_erase    <= bus.erase;
            r_vertical <= bus.vertical;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_xOut   <= '0;
            r_yOut   <= '0;
            r_colour <= '0;
        end else begin
            r_busy <= w_nextBusy;
            r_done <= w_nextDone;
            r_plot <= w_emit;
            if (w_emit) begin
                r_xOut   <= w_nextX;
                r_yOut   <= w_nextY;
                r_colour <= w_nextColour;
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.plot   = r_plot;
    assign bus.x_out  = r_xOut;
    assign bus.y_out  = r_yOut;
    assign bus.colour = r_colour;

endmodule
